instr_loader: RTL and testbench

- Write-side counterpart of the per-node instruction ROM: receives a program image as a byte stream and writes 21-bit opcodes into the node's instruction RAM write port.
- Publishes the loaded program length, and holds the node core stalled while a load is in progress or after a failed load.
- Sits between the host byte link (UART/JTAG bridge, valid/ready) and one node's instruction RAM.

---
 rtl/instr_loader.sv | 145 ++++++++++++++
 tb/tb_instr_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream program loader for one node's instruction RAM. It parses header, opcode and checksum
// frames, writes 21-bit opcodes and holds the core stalled until a load succeeds.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// HDR   | expecting header byte N (opcode count)
// B0    | expecting opcode bits [20:16] (byte[7:5] ignored)
// B1    | expecting opcode bits [15:8]
// B2    | expecting opcode bits [7:0]; write strobe follows
// CSUM  | expecting XOR checksum of header and opcode bytes
module instr_loader #(
  parameter int MAX_ENTRIES    = 32,
  parameter int INIT_ENTRIES   = 10,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [20:0] wr_data,
  output logic [5:0]  num_entries,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  localparam int            TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0]    MAX_N    = 8'(MAX_ENTRIES);
  localparam logic [5:0]    INIT_N   = 6'(INIT_ENTRIES);

  typedef enum logic [2:0] {IDLE, HDR, B0, B1, B2, CSUM} state_t;

  state_t        state;
  logic [5:0]    n_reg;
  logic [4:0]    idx;
  logic [7:0]    csum;
  logic [4:0]    op_hi;
  logic [7:0]    op_mid;
  logic [TW-1:0] tmo_cnt;
  logic          accept;
  logic          last_op;

  assign accept  = in_valid && in_ready;
  assign last_op = ({1'b0, idx} + 6'd1) == n_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      num_entries <= INIT_N;
      core_hold   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      n_reg       <= '0;
      idx         <= '0;
      csum        <= '0;
      op_hi       <= '0;
      op_mid      <= '0;
      tmo_cnt     <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= HDR;
            in_ready  <= 1'b1;
            core_hold <= 1'b1;
            err       <= 1'b0;
            idx       <= '0;
            csum      <= '0;
            tmo_cnt   <= TMO_LOAD;
          end
        end
        default: begin
          if (accept) begin
            tmo_cnt <= TMO_LOAD;
            csum    <= csum ^ in_data;
            case (state)
              HDR: begin
                if (in_data == 8'd0 || in_data > MAX_N) begin
                  err      <= 1'b1;
                  state    <= IDLE;
                  in_ready <= 1'b0;
                end else begin
                  n_reg <= in_data[5:0];
                  state <= B0;
                end
              end
              B0: begin
                op_hi <= in_data[4:0];
                state <= B1;
              end
              B1: begin
                op_mid <= in_data;
                state  <= B2;
              end
              B2: begin
                wr_en   <= 1'b1;
                wr_addr <= idx;
                wr_data <= {op_hi, op_mid, in_data};
                idx     <= idx + 5'd1;
                state   <= last_op ? CSUM : B0;
              end
              CSUM: begin
                // csum here still excludes the checksum byte itself
                if (in_data == csum) begin
                  num_entries <= n_reg;
                  done        <= 1'b1;
                  core_hold   <= 1'b0;
                end else begin
                  err <= 1'b1;
                end
                state    <= IDLE;
                in_ready <= 1'b0;
              end
              default: begin
                state    <= IDLE;
                in_ready <= 1'b0;
              end
            endcase
          end else if (TMO_EN) begin
            if (tmo_cnt == TW'(1)) begin
              err      <= 1'b1;
              state    <= IDLE;
              in_ready <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt - TW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frame loads, checksum and header errors, gaps, timeout and reset.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, core_hold, done, err;
  logic [4:0]  wr_addr;
  logic [20:0] wr_data;
  logic [5:0]  num_entries;

  int          n_vec = 0;
  int          n_miss = 0;
  int          done_cnt = 0;
  logic [4:0]  log_addr[$];
  logic [20:0] log_data[$];
  logic [7:0]  frm[$];
  logic [20:0] exp_ops[32];

  always #5 clk = ~clk;

  instr_loader #(.MAX_ENTRIES(32), .INIT_ENTRIES(10), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_entries(num_entries), .core_hold(core_hold), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (!reset && done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b, input int gap, output bit ok);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap_max, input int start_at, input bit exp_ok);
    int n;
    int gap;
    bit ok;
    clear_log();
    pulse_start();
    check("hold_on_start", core_hold, 1);
    check("ready_on_start", in_ready, 1);
    n = int'(frm[0]);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == start_at) pulse_start();
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      send(frm[i], gap, ok);
      check("byte_accept", ok, 1);
      if (i >= 1 && i <= 3 * n) check("wr_strobe", wr_en, (i % 3 == 0));
      if (i == frm.size() - 1) check("done_latency", done, exp_ok);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after", in_ready, 0);
  endtask

  task automatic check_writes(input int n);
    check("wr_count", log_addr.size(), n);
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      check("wr_addr", log_addr[i], i);
      check("wr_data", log_data[i], exp_ops[i]);
    end
  endtask

  task automatic header_reject(input logic [7:0] n);
    bit ok;
    clear_log();
    pulse_start();
    send(n, 0, ok);
    check("hdr_accept", ok, 1);
    check("hdr_err", err, 1);
    check("hdr_idle", in_ready, 0);
    check("hdr_hold", core_hold, 1);
    repeat (3) @(negedge clk);
    check("hdr_no_wr", log_addr.size(), 0);
  endtask

  initial begin
    bit ok;
    logic [7:0] cs;
    logic [20:0] op;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_num_entries", num_entries, 10);
    check("rst_core_hold", core_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // XOR of 02,01,23,45,00,00,07 is 0x62; 0x65 is a bad checksum.
    exp_ops[0] = 21'h012345;
    exp_ops[1] = 21'h000007;
    frm = {8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07, 8'h65};
    run_frame(0, -1, 1'b0);
    check_writes(2);
    check("bad_done_cnt", done_cnt, 0);
    check("bad_err", err, 1);
    check("bad_num_entries", num_entries, 10);
    check("bad_hold", core_hold, 1);

    frm = {8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07, 8'h62};
    run_frame(0, -1, 1'b1);
    check_writes(2);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_err_cleared", err, 0);
    check("nom_num_entries", num_entries, 2);
    check("nom_hold", core_hold, 0);

    header_reject(8'd0);
    header_reject(8'd33);

    frm = {8'd32};
    cs = 8'd32;
    for (int i = 0; i < 32; i++) begin
      op = {5'(i), 8'(i * 7 + 1), 8'(i ^ 8'hA5)};
      exp_ops[i] = op;
      frm.push_back({3'b000, op[20:16]}); cs ^= {3'b000, op[20:16]};
      frm.push_back(op[15:8]);            cs ^= op[15:8];
      frm.push_back(op[7:0]);             cs ^= op[7:0];
    end
    frm.push_back(cs);
    run_frame(0, -1, 1'b1);
    check_writes(32);
    check("n32_num_entries", num_entries, 32);
    check("n32_err", err, 0);

    exp_ops[0] = 21'h012345;
    exp_ops[1] = 21'h000007;
    frm = {8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07, 8'h62};
    run_frame(5, -1, 1'b1);
    check_writes(2);
    check("gap_num_entries", num_entries, 2);
    check("gap_err", err, 0);

    clear_log();
    pulse_start();
    send(8'h02, 0, ok);
    send(8'h01, 0, ok);
    send(8'h23, 0, ok);
    check("tmo_pre_accept", ok, 1);
    repeat (7) @(negedge clk);
    check("tmo_not_yet", err, 0);
    repeat (2) @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_idle", in_ready, 0);
    check("tmo_hold", core_hold, 1);
    send(8'h45, 0, ok);
    check("tmo_no_accept", ok, 0);
    check("tmo_no_wr", log_addr.size(), 0);

    clear_log();
    pulse_start();
    send(8'h02, 0, ok);
    send(8'h01, 0, ok);
    send(8'h23, 0, ok);
    send(8'h45, 0, ok);
    check("mid_wr_strobe", wr_en, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_in_ready", in_ready, 0);
    check("mid_core_hold", core_hold, 0);
    check("mid_err", err, 0);
    check("mid_num_entries", num_entries, 10);
    check("mid_wr_en", wr_en, 0);
    reset = 1'b0;
    @(negedge clk);

    frm = {8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07, 8'h62};
    run_frame(0, 3, 1'b1);
    check_writes(2);
    check("sdl_num_entries", num_entries, 2);
    check("sdl_err", err, 0);

    // 01^E1^02^03 = 0xE1
    exp_ops[0] = 21'h010203;
    frm = {8'h01, 8'hE1, 8'h02, 8'h03, 8'hE1};
    run_frame(0, -1, 1'b1);
    check_writes(1);
    check("e1_num_entries", num_entries, 1);
    check("e1_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
